// File: rtl/memwb_skid_reg_pkg.sv
// Shared types for the MEM/WB elastic pipeline register.
// The payload struct documents the default-width field layout; the flat vector packing in memwb_skid_reg uses the same order.
package memwb_skid_reg_pkg;

    localparam int unsigned MEMWB_XLEN      = 64;
    localparam int unsigned MEMWB_RF_ADDR_W = 5;
    localparam int unsigned MEMWB_RES_SRC_W = 2;

    typedef struct packed {
        logic [MEMWB_XLEN-1:0]      alu_result;
        logic [MEMWB_XLEN-1:0]      read_data;
        logic [MEMWB_XLEN-1:0]      pc_plus4;
        logic [MEMWB_XLEN-1:0]      ext_imm;
        logic [MEMWB_RF_ADDR_W-1:0] rd;
        logic [MEMWB_RES_SRC_W-1:0] result_src;
        logic                       reg_write;
    } memwb_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/memwb_skid_reg_pipe_skid_buf.sv
// Generic two-entry skid buffer: the main entry drives the output, and the skid entry catches the one payload in flight when the consumer stalls.
module pipe_skid_buf
    import memwb_skid_reg_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept;
    logic         emit;

    // in_ready decodes registered state only, so there is no combinational path from out_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/memwb_skid_reg.sv
// Elastic MEM/WB pipeline register: skid-buffered payload, bubble-qualified register write and a saturating stall counter.
module memwb_skid_reg
    import memwb_skid_reg_pkg::*;
#(
    parameter int unsigned XLEN        = MEMWB_XLEN,
    parameter int unsigned RF_ADDR_W   = MEMWB_RF_ADDR_W,
    parameter int unsigned RES_SRC_W   = MEMWB_RES_SRC_W,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ValidM,
    output logic                   ReadyM,
    input  logic [XLEN-1:0]        ALUResultM,
    input  logic [XLEN-1:0]        ReadData,
    input  logic [XLEN-1:0]        PCPlus4M,
    input  logic [XLEN-1:0]        ExtImmM,
    input  logic [RF_ADDR_W-1:0]   RdM,
    input  logic [RES_SRC_W-1:0]   ResultSrcM,
    input  logic                   RegWriteM,
    input  logic                   FlushM,
    output logic                   ValidW,
    input  logic                   ReadyW,
    output logic [XLEN-1:0]        ALUResultW,
    output logic [XLEN-1:0]        ReadDataW,
    output logic [XLEN-1:0]        PCPlus4W,
    output logic [XLEN-1:0]        ExtImmW,
    output logic [RF_ADDR_W-1:0]   RdW,
    output logic [RES_SRC_W-1:0]   ResultSrcW,
    output logic                   RegWriteW,
    output logic [STALL_CNT_W-1:0] StallCnt
);

    localparam int unsigned PAY_W = 4 * XLEN + RF_ADDR_W + RES_SRC_W + 1;
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

    logic [PAY_W-1:0]       pay_in;
    logic [PAY_W-1:0]       pay_out;
    logic                   reg_write_held;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Field order matches memwb_payload_t so the flat vector follows the shared layout at any width.
    assign pay_in = {ALUResultM, ReadData, PCPlus4M, ExtImmM, RdM, ResultSrcM, RegWriteM};

    pipe_skid_buf #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst),
        .in_valid  (ValidM),
        .in_ready  (ReadyM),
        .in_data   (pay_in),
        .flush     (FlushM),
        .out_valid (ValidW),
        .out_ready (ReadyW),
        .out_data  (pay_out)
    );

    assign {ALUResultW, ReadDataW, PCPlus4W, ExtImmW, RdW, ResultSrcW, reg_write_held} = pay_out;
    assign RegWriteW = reg_write_held & ValidW;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ValidW && !ReadyW && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_memwb_skid_reg.sv
// Directed bench for memwb_skid_reg with hand-computed expectations (STALL_CNT_W=4).
module tb_memwb_skid_reg;

    logic        clk;
    logic        rst;
    logic        ValidM;
    logic        ReadyM;
    logic [63:0] ALUResultM, ReadData, PCPlus4M, ExtImmM;
    logic [4:0]  RdM;
    logic [1:0]  ResultSrcM;
    logic        RegWriteM;
    logic        FlushM;
    logic        ValidW;
    logic        ReadyW;
    logic [63:0] ALUResultW, ReadDataW, PCPlus4W, ExtImmW;
    logic [4:0]  RdW;
    logic [1:0]  ResultSrcW;
    logic        RegWriteW;
    logic [3:0]  StallCnt;

    int unsigned total;
    int unsigned bad;

    memwb_skid_reg #(
        .XLEN        (64),
        .RF_ADDR_W   (5),
        .RES_SRC_W   (2),
        .STALL_CNT_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ValidM     (ValidM),
        .ReadyM     (ReadyM),
        .ALUResultM (ALUResultM),
        .ReadData   (ReadData),
        .PCPlus4M   (PCPlus4M),
        .ExtImmM    (ExtImmM),
        .RdM        (RdM),
        .ResultSrcM (ResultSrcM),
        .RegWriteM  (RegWriteM),
        .FlushM     (FlushM),
        .ValidW     (ValidW),
        .ReadyW     (ReadyW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .ExtImmW    (ExtImmW),
        .RdW        (RdW),
        .ResultSrcW (ResultSrcW),
        .RegWriteW  (RegWriteW),
        .StallCnt   (StallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a payload whose side fields are derived from the ALU value.
    task automatic drive(input logic [63:0] alu, input logic [4:0] rd, input logic rw);
        ValidM     = 1'b1;
        ALUResultM = alu;
        ReadData   = alu << 4;
        PCPlus4M   = alu + 64'd4;
        ExtImmM    = alu ^ 64'hFF;
        RdM        = rd;
        ResultSrcM = 2'b10;
        RegWriteM  = rw;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; ValidM = 1'b0; ReadyW = 1'b0; FlushM = 1'b0;
        ALUResultM = '0; ReadData = '0; PCPlus4M = '0; ExtImmM = '0;
        RdM = '0; ResultSrcM = '0; RegWriteM = 1'b0;

        #12;
        chk("rst_validw",   64'(ValidW),    64'd0);
        chk("rst_readym",   64'(ReadyM),    64'd1);
        chk("rst_regwrite", 64'(RegWriteW), 64'd0);
        chk("rst_alu",      ALUResultW,     64'd0);
        chk("rst_stall",    64'(StallCnt),  64'd0);
        rst = 1'b1;

        // Streaming at full throughput.
        ReadyW = 1'b1;
        drive(64'h10, 5'd3, 1'b1);
        step();
        chk("s1_alu",     ALUResultW,     64'h10);
        chk("s1_rd",      ReadDataW,      64'h100);
        chk("s1_pc",      PCPlus4W,       64'h14);
        chk("s1_imm",     ExtImmW,        64'hEF);
        chk("s1_rdw",     64'(RdW),       64'd3);
        chk("s1_src",     64'(ResultSrcW), 64'd2);
        chk("s1_regw",    64'(RegWriteW), 64'd1);
        chk("s1_readym",  64'(ReadyM),    64'd1);
        drive(64'h20, 5'd3, 1'b1);
        step();
        chk("s2_alu",    ALUResultW,  64'h20);
        chk("s2_readym", 64'(ReadyM), 64'd1);
        drive(64'h30, 5'd3, 1'b1);
        step();
        chk("s3_alu",    ALUResultW,  64'h30);
        chk("s3_readym", 64'(ReadyM), 64'd1);
        ValidM = 1'b0;
        step();
        chk("s_drain_valid", 64'(ValidW),    64'd0);
        chk("s_drain_regw",  64'(RegWriteW), 64'd0);
        chk("s_drain_stale", ALUResultW,     64'h30);
        chk("s_stall",       64'(StallCnt),  64'd0);

        // Back-pressure: A on W, B in skid, C held upstream.
        ReadyW = 1'b0;
        drive(64'hA1, 5'd1, 1'b1);
        step();
        chk("bp_a_alu",    ALUResultW,  64'hA1);
        chk("bp_a_readym", 64'(ReadyM), 64'd1);
        drive(64'hB2, 5'd2, 1'b1);
        step();
        chk("bp_b_alu",    ALUResultW,  64'hA1);
        chk("bp_b_readym", 64'(ReadyM), 64'd0);
        drive(64'hC3, 5'd4, 1'b1);
        step();
        chk("bp_c_alu",    ALUResultW,    64'hA1);
        chk("bp_c_readym", 64'(ReadyM),   64'd0);
        chk("bp_stall",    64'(StallCnt), 64'd2);
        ReadyW = 1'b1;
        step();
        chk("bp_emit_b",   ALUResultW,  64'hB2);
        chk("bp_emit_brd", 64'(RdW),    64'd2);
        chk("bp_readym",   64'(ReadyM), 64'd1);
        step();
        chk("bp_emit_c",   ALUResultW, 64'hC3);
        chk("bp_emit_crd", 64'(RdW),   64'd4);
        ValidM = 1'b0;
        step();
        chk("bp_empty",    64'(ValidW),   64'd0);
        chk("bp_stall2",   64'(StallCnt), 64'd2);

        // Flush while FULL with an incoming payload.
        ReadyW = 1'b0;
        drive(64'hD4, 5'd5, 1'b1);
        step();
        drive(64'hE5, 5'd6, 1'b1);
        step();
        chk("fl_full_readym", 64'(ReadyM), 64'd0);
        drive(64'hF6, 5'd7, 1'b1);
        FlushM = 1'b1;
        step();
        chk("fl_validw", 64'(ValidW),    64'd0);
        chk("fl_regw",   64'(RegWriteW), 64'd0);
        chk("fl_readym", 64'(ReadyM),    64'd1);
        chk("fl_stale",  ALUResultW,     64'hD4);
        chk("fl_stall",  64'(StallCnt),  64'd4);
        FlushM = 1'b0;
        ValidM = 1'b0;
        ReadyW = 1'b1;
        step();
        chk("fl_no_f", 64'(ValidW), 64'd0);

        // Bubbles never write.
        RegWriteM = 1'b1;
        RdM       = 5'd7;
        step();
        chk("bub_valid", 64'(ValidW),    64'd0);
        chk("bub_regw",  64'(RegWriteW), 64'd0);
        drive(64'h55, 5'd9, 1'b1);
        step();
        chk("bub_live_regw", 64'(RegWriteW), 64'd1);
        chk("bub_live_rd",   64'(RdW),       64'd9);
        ValidM = 1'b0;
        step();
        chk("bub_after_regw", 64'(RegWriteW), 64'd0);
        chk("bub_after_rd",   64'(RdW),       64'd9);

        // Stall counter saturation, then flush leaves it alone.
        ReadyW = 1'b0;
        drive(64'h77, 5'd10, 1'b0);
        step();
        ValidM = 1'b0;
        chk("sat_start", 64'(StallCnt), 64'd4);
        for (int i = 0; i < 20; i++) step();
        chk("sat_15",    64'(StallCnt), 64'd15);
        chk("sat_hold",  ALUResultW,    64'h77);
        FlushM = 1'b1;
        step();
        FlushM = 1'b0;
        chk("sat_flush_valid", 64'(ValidW),   64'd0);
        chk("sat_flush_cnt",   64'(StallCnt), 64'd15);
        step();
        chk("sat_after", 64'(StallCnt), 64'd15);

        // Asynchronous reset while FULL.
        drive(64'h88, 5'd11, 1'b1);
        step();
        drive(64'h99, 5'd12, 1'b1);
        step();
        ValidM = 1'b0;
        chk("ar_full", 64'(ReadyM), 64'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_validw", 64'(ValidW),    64'd0);
        chk("ar_readym", 64'(ReadyM),    64'd1);
        chk("ar_regw",   64'(RegWriteW), 64'd0);
        chk("ar_alu",    ALUResultW,     64'd0);
        chk("ar_rd",     64'(RdW),       64'd0);
        chk("ar_stall",  64'(StallCnt),  64'd0);
        #2;
        rst    = 1'b1;
        ReadyW = 1'b1;
        step();
        chk("ar_no_skid", 64'(ValidW), 64'd0);
        drive(64'h5A, 5'd13, 1'b1);
        step();
        ValidM = 1'b0;
        chk("ar_resume", ALUResultW, 64'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memwb_skid_reg.md
# memwb_skid_reg

Parametrised, elastic MEM/WB pipeline register with a valid/ready handshake on both sides and a two-entry skid buffer. It sits between the Memory and Write-Back stages and replaces the fixed 64-bit always-advance latch. It carries the same payload as that latch. It adds back-pressure, a synchronous flush, bubble-qualified register-write outputs and a saturating stall counter.

## Interface
- XLEN, 64: data path width of ALU result, read data, PC+4 and immediate.
- RF_ADDR_W, 5: destination register index width.
- RES_SRC_W, 2: result-source select width.
- STALL_CNT_W, 32: width of the stall performance counter.
---
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset). Synchronous release is handled upstream.
- ValidM  in  1  MEM-stage payload valid.
- ReadyM  out  1  block can accept a payload this cycle.
- ALUResultM, ReadData, PCPlus4M, ExtImmM  in  XLEN each  MEM payload data.
- RdM  in  RF_ADDR_W  destination register.
- ResultSrcM  in  RES_SRC_W  result-source select.
- RegWriteM  in  1  register write enable.
- FlushM  in  1  synchronous flush; discards every held and incoming payload.
- ValidW  out  1  WB payload valid.
- ReadyW  in  1  WB stage consumes the payload this cycle.
- ALUResultW, ReadDataW, PCPlus4W, ExtImmW  out  XLEN  WB payload data.
- RdW  out  RF_ADDR_W, ResultSrcW  out  RES_SRC_W  WB payload control.
- RegWriteW  out  1  equals held RegWrite AND ValidW. A bubble never writes.
- StallCnt  out  STALL_CNT_W  number of cycles with ValidW=1 and ReadyW=0. Saturates at all-ones.

## Operation
- accept = ValidM & ReadyM; emit = ValidW & ReadyW.
- Storage: main register (drives W outputs) and skid register; state ∈ {EMPTY, ONE, FULL}.
- ReadyM = (state != FULL). It is a registered decode with no combinational path from ReadyW.
- ValidW = (state != EMPTY).
- EMPTY: accept → main←M, ONE. Otherwise stay.
- ONE, accept & emit: main←M, stay ONE.
- ONE, accept & !emit: skid←M, FULL.
- ONE, !accept & emit: EMPTY. Main data holds its stale value.
- ONE, neither: hold.
- FULL: no accept is possible. emit → main←skid, ONE. Otherwise hold.
- FlushM=1 has priority over all of the above. Next state is EMPTY and any incoming accept is dropped. Data registers are not cleared, and StallCnt is not affected.
- Payload ordering is strict FIFO and no payload is ever duplicated or lost except by flush.
- StallCnt increments by 1 in each cycle where ValidW & !ReadyW. At 2^STALL_CNT_W−1 it holds.

## Timing
- Reset (rst=0, asynchronous) sets:
  - state EMPTY, so ValidW=0, ReadyM=1, RegWriteW=0.
  - All data/control outputs 0, and StallCnt 0.
- Latency: a payload accepted at edge N appears on W outputs after edge N (one cycle) when the block was EMPTY or emitting.
- Throughput: one payload per cycle when ReadyW stays high.
- ReadyW dropping costs no payload: the skid captures the one in flight.
- Reset asserted mid-operation discards main and skid contents immediately, with no edge required.
- ValidW and payload are stable while ValidW & !ReadyW (AXI-style hold rule).

## Structure
- The shared core package holds:
  - memwb_payload_t, a packed struct of the seven payload fields, sized by XLEN/RF_ADDR_W/RES_SRC_W.
  - The state enum skid_state_t {EMPTY, ONE, FULL}.
- One sub-module, pipe_skid_buf, is a generic two-entry skid buffer parametrised by payload width. It owns the state machine and flush.
- memwb_skid_reg instantiates pipe_skid_buf and adds:
  - payload packing and unpacking;
  - RegWriteW qualification;
  - the stall counter.

## Test plan
- **Reset mid-stream:** fill to FULL, pull rst low between edges → ValidW=0, ReadyM=1 and all outputs 0 immediately, with no edge required.
- **Streaming:** ReadyW=1, push ALUResultM=0x10,0x20,0x30 on consecutive cycles → ALUResultW shows 0x10,0x20,0x30 one cycle later each, ReadyM stays 1.
- **Back-pressure:** stream A,B,C with ReadyW=0 from cycle 1 → A holds on W, B lands in skid, ReadyM=0, C is held upstream.
  - Then release ReadyW → A, B, C are emitted in order with no duplicates.
- **Flush in FULL with ValidM=1:** assert FlushM → next cycle ValidW=0, RegWriteW=0 and ReadyM=1. The incoming payload never appears.
- **Bubble:** RegWriteM=1 with ValidM=0 → RegWriteW stays 0. An emit leaving EMPTY drives RegWriteW=0 while RdW keeps its stale value.
- **StallCnt saturation:** STALL_CNT_W=4, hold ValidW=1 and ReadyW=0 for 20 cycles → count reads 15 and holds. FlushM leaves the count unchanged.
